// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters, the register file write port and
// the hazard unit. The requester/hazard side uses master, the arbiter uses slave.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
);
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              grant_id;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              rs_pending;
  logic              rt_pending;
  logic [CNT_W-1:0]  zero_drop_cnt;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output rs_addr, rt_addr,
    input  req0_ready, req1_ready,
    input  wr_en, wr_addr, wr_data, grant_id,
    input  rs_pending, rt_pending, zero_drop_cnt
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  rs_addr, rt_addr,
    output req0_ready, req1_ready,
    output wr_en, wr_addr, wr_data, grant_id,
    output rs_pending, rt_pending, zero_drop_cnt
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter for the register file write port:
// 1-entry holding buffer per port, age-first then round-robin grant, $zero suppression.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input logic                    clk_i,
  input logic                    rst_i,
  regfile_write_arbiter_if.slave bus_io
);

  logic [1:0]        in_valid;
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        ready;
  logic [1:0]        acc;
  logic [1:0]        gnt;
  logic              gnt_any;
  logic              gnt_id;

  logic [1:0]        hold_v_q, hold_v_d;
  logic [ADDR_W-1:0] hold_addr_q [2];
  logic [ADDR_W-1:0] hold_addr_d [2];
  logic [DATA_W-1:0] hold_data_q [2];
  logic [DATA_W-1:0] hold_data_d [2];

  // older_q names the holder that has waited longer; tie_q marks a same-edge load.
  logic              older_q, older_d;
  logic              tie_q, tie_d;
  logic              rr_last_q, rr_last_d;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              grant_id_q, grant_id_d;
  logic [CNT_W-1:0]  zero_cnt_q, zero_cnt_d;

  assign in_valid   = {bus_io.req1_valid, bus_io.req0_valid};
  assign in_addr[0] = bus_io.req0_addr;
  assign in_addr[1] = bus_io.req1_addr;
  assign in_data[0] = bus_io.req0_data;
  assign in_data[1] = bus_io.req1_data;

  always_comb begin
    gnt_any = hold_v_q[0] | hold_v_q[1];
    gnt_id  = 1'b0;
    if (hold_v_q[0] && hold_v_q[1]) begin
      gnt_id = tie_q ? ~rr_last_q : older_q;
    end else if (hold_v_q[1]) begin
      gnt_id = 1'b1;
    end
    gnt[0] = gnt_any && !gnt_id;
    gnt[1] = gnt_any && gnt_id;
  end

  // Ready looks at this cycle's grant so a draining buffer refills on the same edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign ready[gi] = !rst_i && (!hold_v_q[gi] || gnt[gi]);
    assign acc[gi]   = in_valid[gi] && ready[gi];
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hold_v_d[p]    = hold_v_q[p];
      hold_addr_d[p] = hold_addr_q[p];
      hold_data_d[p] = hold_data_q[p];
      if (acc[p]) begin
        hold_v_d[p]    = 1'b1;
        hold_addr_d[p] = in_addr[p];
        hold_data_d[p] = in_data[p];
      end else if (gnt[p]) begin
        hold_v_d[p] = 1'b0;
      end
    end
  end

  // A lone load leaves the other (still valid) holder as the older one.
  always_comb begin
    older_d   = older_q;
    tie_d     = tie_q;
    rr_last_d = gnt_any ? gnt_id : rr_last_q;
    if (acc[0] && acc[1]) begin
      tie_d = 1'b1;
    end else if (acc[0]) begin
      tie_d   = 1'b0;
      older_d = 1'b1;
    end else if (acc[1]) begin
      tie_d   = 1'b0;
      older_d = 1'b0;
    end
  end

  always_comb begin
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    grant_id_d = grant_id_q;
    zero_cnt_d = zero_cnt_q;
    if (gnt_any) begin
      wr_addr_d  = hold_addr_q[gnt_id];
      wr_data_d  = hold_data_q[gnt_id];
      grant_id_d = gnt_id;
      wr_en_d    = (hold_addr_q[gnt_id] != '0);
      if (hold_addr_q[gnt_id] == '0 && zero_cnt_q != '1) begin
        zero_cnt_d = zero_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_v_q   <= '0;
      for (int p = 0; p < 2; p++) begin
        hold_addr_q[p] <= '0;
        hold_data_q[p] <= '0;
      end
      older_q    <= 1'b0;
      tie_q      <= 1'b0;
      rr_last_q  <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= 1'b0;
      zero_cnt_q <= '0;
    end else begin
      hold_v_q   <= hold_v_d;
      for (int p = 0; p < 2; p++) begin
        hold_addr_q[p] <= hold_addr_d[p];
        hold_data_q[p] <= hold_data_d[p];
      end
      older_q    <= older_d;
      tie_q      <= tie_d;
      rr_last_q  <= rr_last_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      grant_id_q <= grant_id_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

  function automatic logic pending(input logic [ADDR_W-1:0] a);
    return (a != '0) &&
           ((hold_v_q[0] && hold_addr_q[0] == a) ||
            (hold_v_q[1] && hold_addr_q[1] == a) ||
            (wr_en_q && wr_addr_q == a));
  endfunction

  assign bus_io.req0_ready    = ready[0];
  assign bus_io.req1_ready    = ready[1];
  assign bus_io.wr_en         = wr_en_q;
  assign bus_io.wr_addr       = wr_addr_q;
  assign bus_io.wr_data       = wr_data_q;
  assign bus_io.grant_id      = grant_id_q;
  assign bus_io.zero_drop_cnt = zero_cnt_q;
  assign bus_io.rs_pending    = pending(bus_io.rs_addr);
  assign bus_io.rt_pending    = pending(bus_io.rt_addr);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed plus random stimulus for regfile_write_arbiter, checked against a
// timestamp-based arbitration model and a shadow register file.
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_asrt = 0;
  int   n_fail = 0;

  regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(8)) bus ();

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  // Model: each buffered entry carries the cycle it was accepted in.
  bit          m_v [2];
  bit [4:0]    m_a [2];
  bit [31:0]   m_d [2];
  int          m_t [2];
  bit          m_rr;
  bit          o_en;
  bit [4:0]    o_a;
  bit [31:0]   o_d;
  bit          o_g;
  int          m_z;
  int          cyc;
  logic [31:0] exp_rf [32];
  logic [31:0] dut_rf [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_v[0] = 0; m_v[1] = 0;
    m_rr = 1; o_en = 0; o_a = 0; o_d = 0; o_g = 0; m_z = 0;
  endtask

  function automatic int pick();
    if (!m_v[0] && !m_v[1]) return -1;
    if (m_v[0] && !m_v[1]) return 0;
    if (m_v[1] && !m_v[0]) return 1;
    if (m_t[0] < m_t[1]) return 0;
    if (m_t[1] < m_t[0]) return 1;
    return m_rr ? 0 : 1;
  endfunction

  function automatic bit m_pend(input bit [4:0] a);
    return (a != 0) && ((m_v[0] && m_a[0] == a) || (m_v[1] && m_a[1] == a) || (o_en && o_a == a));
  endfunction

  task automatic cycle(input bit v0, input bit [4:0] a0, input bit [31:0] d0,
                       input bit v1, input bit [4:0] a1, input bit [31:0] d1,
                       input bit [4:0] rs, input bit [4:0] rt);
    int g;
    bit rdy0, rdy1;
    @(negedge clk);
    if (bus.wr_en === 1'b1) dut_rf[bus.wr_addr] = bus.wr_data;
    if (o_en) exp_rf[o_a] = o_d;
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    bus.rs_addr = rs; bus.rt_addr = rt;
    #1;
    g = pick();
    rdy0 = !m_v[0] || g == 0;
    rdy1 = !m_v[1] || g == 1;
    chk("req0_ready", bus.req0_ready, rdy0);
    chk("req1_ready", bus.req1_ready, rdy1);
    chk("wr_en", bus.wr_en, o_en);
    chk("wr_addr", bus.wr_addr, o_a);
    chk("wr_data", bus.wr_data, o_d);
    chk("grant_id", bus.grant_id, o_g);
    chk("rs_pending", bus.rs_pending, m_pend(rs));
    chk("rt_pending", bus.rt_pending, m_pend(rt));
    chk("zero_drop_cnt", bus.zero_drop_cnt, m_z);
    if (g >= 0) begin
      o_en = m_a[g] != 0; o_a = m_a[g]; o_d = m_d[g]; o_g = g[0];
      if (m_a[g] == 0 && m_z < 255) m_z++;
      m_rr = g[0];
      m_v[g] = 0;
    end else begin
      o_en = 0;
    end
    if (v0 && rdy0) begin m_v[0] = 1; m_a[0] = a0; m_d[0] = d0; m_t[0] = cyc; end
    if (v1 && rdy1) begin m_v[1] = 1; m_a[1] = a1; m_d[1] = d1; m_t[1] = cyc; end
    cyc++;
  endtask

  task automatic idle(input bit [4:0] rs = 0, input bit [4:0] rt = 0);
    cycle(0, 0, 0, 0, 0, 0, rs, rt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    #1;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_zero_cnt", bus.zero_drop_cnt, 0);
    @(posedge clk);
    #1;
    rst = 0;
    m_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 0; bus.req0_addr = 0; bus.req0_data = 0;
    bus.req1_valid = 0; bus.req1_addr = 0; bus.req1_data = 0;
    bus.rs_addr = 0; bus.rt_addr = 0;
    for (int r = 0; r < 32; r++) begin exp_rf[r] = 0; dut_rf[r] = 0; end
    cyc = 0;
    m_reset();

    // Single write on port 0
    do_reset();
    cycle(1, 8, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    idle();
    idle();
    chk("single_wr_en", bus.wr_en, 1);
    chk("single_wr_addr", bus.wr_addr, 8);
    chk("single_grant_id", bus.grant_id, 0);
    idle();
    chk("single_rf8", dut_rf[8], 32'hDEADBEEF);

    // Same-edge tie: port 0 first after reset
    do_reset();
    cycle(1, 9, 32'h99, 1, 10, 32'hAA, 0, 0);
    idle();
    chk("tie_ready1_low", bus.req1_ready, 0);
    idle();
    chk("tie_first_gid", bus.grant_id, 0);
    chk("tie_ready1_back", bus.req1_ready, 1);
    idle();
    chk("tie_second_gid", bus.grant_id, 1);
    cycle(1, 11, 32'hB1, 1, 13, 32'hD1, 0, 0);
    repeat (4) idle();

    // Age ordering on register 12
    do_reset();
    cycle(1, 20, 32'h20, 1, 21, 32'h21, 0, 0);
    cycle(1, 22, 32'h22, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 12, 32'h1, 0, 0);
    cycle(1, 12, 32'h2, 0, 0, 0, 12, 0);
    repeat (4) idle(12, 0);
    chk("age_rf12", dut_rf[12], 32'h2);

    // $zero suppression and saturation
    do_reset();
    cycle(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    idle();
    idle();
    chk("zero_cnt_one", bus.zero_drop_cnt, 1);
    for (int i = 0; i < 300; i++) cycle(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    repeat (3) idle();
    chk("zero_cnt_sat", bus.zero_drop_cnt, 255);
    chk("zero_rf0", dut_rf[0], 0);

    // Pending flags
    do_reset();
    cycle(1, 5, 32'h55, 0, 0, 0, 5, 0);
    idle(5, 0);
    chk("pend_rs_hold", bus.rs_pending, 1);
    chk("pend_rt_zero", bus.rt_pending, 0);
    idle(5, 0);
    idle(5, 0);
    chk("pend_rs_clear", bus.rs_pending, 0);

    // Asynchronous reset while a write is in flight
    do_reset();
    cycle(1, 6, 32'h66, 1, 7, 32'h77, 7, 14);
    cycle(1, 14, 32'hEE, 0, 0, 0, 7, 14);
    @(posedge clk);
    #2;
    chk("mid_pre_wr_en", bus.wr_en, 1);
    rst = 1;
    #1;
    chk("mid_wr_en", bus.wr_en, 0);
    chk("mid_ready0", bus.req0_ready, 0);
    chk("mid_ready1", bus.req1_ready, 0);
    chk("mid_rs_pend", bus.rs_pending, 0);
    chk("mid_rt_pend", bus.rt_pending, 0);
    @(posedge clk);
    #1;
    rst = 0;
    m_reset();
    repeat (3) idle(7, 14);
    chk("mid_rf6", dut_rf[6], 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 5'($urandom_range(0, 15)), $urandom,
            1'($urandom), 5'($urandom_range(0, 15)), $urandom,
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end
    repeat (4) idle();

    for (int r = 0; r < 32; r++) chk($sformatf("rf%0d", r), dut_rf[r], exp_rf[r]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
